enc_dec_apb_front: RTL

ENC_DEC_APB_FRONT -- requirements
Module: enc_dec_apb_front

---
 rtl/enc_dec_apb_pkg.sv | 14 +
 rtl/enc_dec_apb_regs.sv | 42 ++++
 rtl/enc_dec_apb_front.sv | 83 ++++++++
 3 files changed

// File: rtl/enc_dec_apb_pkg.sv
// enc_dec_apb_pkg: shared types and constants for the APB front end of the codec
package enc_dec_apb_pkg;
   typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
   localparam logic [1:0] REG_CTRL    = 2'd0;
   localparam logic [1:0] REG_DATA_IN = 2'd1;
   localparam logic [1:0] REG_CW      = 2'd2;
   localparam logic [1:0] REG_NOISE   = 2'd3;
   localparam logic [1:0] MODE_ENC    = 2'd0;
   localparam logic [1:0] MODE_DEC    = 2'd1;
   localparam logic [1:0] MODE_FULL   = 2'd2;
   localparam logic [1:0] MODE_NONE   = 2'd3;
   localparam logic [7:0] WD_LIMIT    = 8'd255;
   localparam logic [1:0] NOF_TIMEOUT = 2'b11;
endpackage

// File: rtl/enc_dec_apb_regs.sv
// enc_dec_apb_regs: APB register bank with setup-phase readback and launch detect
module enc_dec_apb_regs
   import enc_dec_apb_pkg::*;
#(
   parameter int AMBA_WORD  = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            addr,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [AMBA_WORD-1:0]  PWDATA,
   input  logic                  busy,
   output logic [AMBA_WORD-1:0]  PRDATA,
   output logic [1:0]            ctrl,
   output logic [DATA_WIDTH-1:0] data_in,
   output logic [1:0]            cw_width,
   output logic [DATA_WIDTH-1:0] noise,
   output logic                  launch
);
   logic [AMBA_WORD-1:0] regs [4];
   logic wr, rd;
   assign wr       = PSEL & PENABLE & PWRITE & ~busy;
   assign rd       = PSEL & ~PENABLE & ~PWRITE;
   // a CTRL write of MODE_NONE is stored but never starts the core
   assign launch   = wr && addr == REG_CTRL && PWDATA[1:0] != MODE_NONE;
   assign ctrl     = regs[REG_CTRL][1:0];
   assign cw_width = regs[REG_CW][1:0];
   assign data_in  = DATA_WIDTH'(regs[REG_DATA_IN]);
   assign noise    = DATA_WIDTH'(regs[REG_NOISE]);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) regs[i] <= '0;
         PRDATA <= '0;
      end else begin
         if (wr) regs[addr] <= PWDATA;
         if (rd) PRDATA <= regs[addr];
      end
   end
endmodule

// File: rtl/enc_dec_apb_front.sv
// enc_dec_apb_front: APB front end that launches the codec core and latches its result
module enc_dec_apb_front
   import enc_dec_apb_pkg::*;
#(
   parameter int AMBA_ADDR_WIDTH = 20,
   parameter int AMBA_WORD       = 32,
   parameter int DATA_WIDTH      = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
   input  logic                       PSEL,
   input  logic                       PENABLE,
   input  logic                       PWRITE,
   input  logic [AMBA_WORD-1:0]       PWDATA,
   output logic [AMBA_WORD-1:0]       PRDATA,
   output logic [1:0]                 ctrl,
   output logic [DATA_WIDTH-1:0]      data_in,
   output logic [1:0]                 cw_width,
   output logic [DATA_WIDTH-1:0]      noise,
   output logic                       start,
   input  logic                       core_done,
   input  logic [DATA_WIDTH-1:0]      core_data,
   input  logic [1:0]                 core_nof,
   output logic                       operation_done,
   output logic [DATA_WIDTH-1:0]      data_out,
   output logic [1:0]                 num_of_errors,
   output logic                       busy
);
   state_t     state;
   logic [7:0] wd;
   logic       launch;
   logic       unused_addr;
   assign unused_addr = ^{PADDR[AMBA_ADDR_WIDTH-1:4], PADDR[1:0]};
   enc_dec_apb_regs #(.AMBA_WORD(AMBA_WORD), .DATA_WIDTH(DATA_WIDTH)) u_regs (
      .clk(clk), .rst(rst), .addr(PADDR[3:2]), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PWDATA(PWDATA), .busy(busy), .PRDATA(PRDATA), .ctrl(ctrl),
      .data_in(data_in), .cw_width(cw_width), .noise(noise), .launch(launch)
   );
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         start          <= 1'b0;
         operation_done <= 1'b0;
         busy           <= 1'b0;
         wd             <= '0;
         data_out       <= '0;
         num_of_errors  <= '0;
      end else begin
         case (state)
            IDLE: if (launch) begin
               state <= START;
               start <= 1'b1;
               busy  <= 1'b1;
            end
            START: begin
               state <= WAIT;
               start <= 1'b0;
               wd    <= '0;
            end
            WAIT: if (core_done) begin
               data_out       <= core_data;
               num_of_errors  <= core_nof;
               operation_done <= 1'b1;
               state          <= DONE;
            end else if (wd == WD_LIMIT - 8'd1) begin
               // counter reaches the limit on this edge: give up on the core
               wd             <= WD_LIMIT;
               data_out       <= '0;
               num_of_errors  <= NOF_TIMEOUT;
               operation_done <= 1'b1;
               state          <= DONE;
            end else wd <= wd + 8'd1;
            DONE: begin
               operation_done <= 1'b0;
               busy           <= 1'b0;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
